// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: refresh-paced strip frame sequencer with round-robin arbitration
// between two pixel sources, feeding a 32-bit word serializer over valid/ready.
module matrix_frame_scheduler #(
   parameter int NUM_LEDS    = 64,
   parameter int END_WORDS   = 2,
   parameter int REFRESH_DIV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        src0_req,
   input  logic        src1_req,
   output logic [1:0]  grant,
   output logic        rd_en,
   output logic [5:0]  rd_idx,
   input  logic [31:0] src0_data,
   input  logic [31:0] src1_data,
   output logic        word_valid,
   output logic [31:0] word_data,
   input  logic        word_ready,
   output logic        frame_busy,
   output logic        frame_done,
   output logic        overrun
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int TW = $clog2(END_WORDS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [5:0]    IDX_LAST = 6'(NUM_LEDS - 1);
   localparam logic [TW-1:0] TRL_LAST = TW'(END_WORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_FETCH, S_DATA, S_END} state_t;

   state_t        state, state_next;
   logic [CW-1:0] ref_cnt;
   logic [TW-1:0] trl_cnt;
   logic          tick, tick_pending, consume, last_grant, pick_src1, first;
   logic [31:0]   src_word, data_q;

   assign tick      = ref_cnt == CNT_LAST;
   assign consume   = state == S_IDLE && tick_pending && enable && (src0_req || src1_req);
   // last_grant = 1 means src1 owned the previous frame
   assign pick_src1 = (src0_req && src1_req) ? ~last_grant : src1_req;
   assign src_word  = grant[1] ? src1_data : src0_data;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      frame_done = 1'b0;
      frame_busy = state != S_IDLE;
      unique case (state)
         S_IDLE:  state_next = consume ? S_ARB : S_IDLE;
         S_ARB:   state_next = (src0_req || src1_req) ? S_START : S_IDLE;
         S_START: begin
            word_valid = 1'b1;
            state_next = word_ready ? S_FETCH : S_START;
         end
         S_FETCH: begin
            rd_en      = 1'b1;
            state_next = S_DATA;
         end
         S_DATA: begin
            word_valid = 1'b1;
            // source word is only valid in the first DATA cycle; hold the captured copy after
            word_data  = first ? src_word : data_q;
            if (word_ready) state_next = (rd_idx == IDX_LAST) ? S_END : S_FETCH;
         end
         S_END: begin
            word_valid = 1'b1;
            frame_done = word_ready && trl_cnt == TRL_LAST;
            state_next = frame_done ? S_IDLE : S_END;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt      <= '0;
         tick_pending <= 1'b0;
         overrun      <= 1'b0;
         grant        <= 2'b00;
         last_grant   <= 1'b1;
         rd_idx       <= '0;
         trl_cnt      <= '0;
         first        <= 1'b0;
         data_q       <= '0;
      end else begin
         ref_cnt      <= tick ? '0 : ref_cnt + CW'(1);
         tick_pending <= tick || (tick_pending && !consume);
         overrun      <= overrun || (tick && tick_pending);
         first        <= state == S_FETCH;
         if (state == S_ARB && (src0_req || src1_req)) begin
            grant      <= pick_src1 ? 2'b10 : 2'b01;
            last_grant <= pick_src1;
         end
         if (state == S_START && word_ready) rd_idx <= '0;
         if (state == S_DATA && first) data_q <= src_word;
         if (state == S_DATA && word_ready) begin
            if (rd_idx != IDX_LAST) rd_idx <= rd_idx + 6'd1;
            trl_cnt <= '0;
         end
         if (frame_done) grant <= 2'b00;
         else if (state == S_END && word_ready) trl_cnt <= trl_cnt + TW'(1);
      end
   end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler: directed scenario bench for the frame scheduler; a second
// instance with a short refresh period exercises back-to-back frames and overrun.
module tb_matrix_frame_scheduler;
   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, src0_req = 1'b0, src1_req = 1'b0, word_ready = 1'b0;
   logic [31:0] src0_data = '0, src1_data = '0;
   logic [1:0]  grant;
   logic        rd_en, word_valid, frame_busy, frame_done, overrun;
   logic [5:0]  rd_idx;
   logic [31:0] word_data;
   logic [1:0]  grant4;
   logic        rd_en4, wv4, busy4, done4, ovr4;
   logic [5:0]  rd_idx4;
   logic [31:0] wd4;
   int          n_pass = 0, n_tot = 0;
   logic [31:0] got [0:127];
   int          nw, ncyc, unstable, gbad;
   logic [1:0]  fgrant;

   matrix_frame_scheduler dut (
      .clk(clk), .reset(reset), .enable(enable), .src0_req(src0_req), .src1_req(src1_req),
      .grant(grant), .rd_en(rd_en), .rd_idx(rd_idx), .src0_data(src0_data), .src1_data(src1_data),
      .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
      .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun));

   matrix_frame_scheduler #(.REFRESH_DIV(100)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .src0_req(src0_req), .src1_req(src1_req),
      .grant(grant4), .rd_en(rd_en4), .rd_idx(rd_idx4), .src0_data({26'd0, rd_idx4}),
      .src1_data({26'd0, rd_idx4}), .word_valid(wv4), .word_data(wd4), .word_ready(word_ready),
      .frame_busy(busy4), .frame_done(done4), .overrun(ovr4));

   always #5 clk = ~clk;

   // pixel sources: word for the strobed index appears the cycle after rd_en
   always @(posedge clk) begin
      if (rd_en) begin
         src0_data <= {26'd0, rd_idx} * 32'd3;
         src1_data <= 32'hA000_0000 | {26'd0, rd_idx};
      end
   end

   task automatic cyc(input logic rdy);
      @(negedge clk);
      word_ready = rdy;
      #1;
   endtask

   function automatic logic [31:0] exp_word(input logic s1, input int i);
      if (i == 0 || i > 64) return 32'd0;
      return s1 ? (32'hA000_0000 | 32'(i - 1)) : 32'((i - 1) * 3);
   endfunction

   function automatic int count_bad(input logic s1);
      int bad = 0;
      for (int i = 0; i < 67; i++) if (got[i] !== exp_word(s1, i)) bad++;
      return bad;
   endfunction

   // waits for the next frame, then records accepted words until frame_done
   task automatic run_frame(input logic stall);
      int c = 0, k = 0;
      logic pv = 1'b0;
      logic [31:0] pd = '0;
      nw = 0; ncyc = 0; unstable = 0; gbad = 0; fgrant = 2'b00;
      for (int i = 0; i < 128; i++) got[i] = 32'hDEAD_BEEF;
      cyc(1'b1);
      while (!frame_busy && c < 1500) begin cyc(1'b1); c++; end
      while (frame_busy && c < 3000) begin
         ncyc++;
         if (pv && (!word_valid || word_data !== pd)) unstable++;
         if (ncyc == 2) fgrant = grant;
         else if (ncyc > 2 && grant !== fgrant) gbad++;
         if (word_valid && word_ready && nw < 128) begin got[nw] = word_data; nw++; end
         if (frame_done) break;
         pv = word_valid && !word_ready;
         pd = word_data;
         cyc(stall ? logic'(k % 3 == 0) : 1'b1);
         k++; c++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cyc(1'b1);
      n_tot++;
      if ({grant, rd_en, rd_idx, word_valid, word_data, frame_busy, frame_done, overrun} !== 45'd0) begin
         $display("FAIL reset_outputs: got %h want 0",
                  {grant, rd_en, rd_idx, word_valid, word_data, frame_busy, frame_done, overrun});
      end else n_pass++;
      reset = 1'b0; enable = 1'b1; src0_req = 1'b1;
      repeat (20) cyc(1'b1);
      n_tot++;
      if (frame_busy !== 1'b0) $display("FAIL reset_no_early_frame: busy=%b want 0", frame_busy);
      else n_pass++;
   endtask

   task automatic test_single_source();
      run_frame(1'b0);
      n_tot++;
      if (nw !== 67) $display("FAIL single_word_count: got %0d want 67", nw); else n_pass++;
      n_tot++;
      if (count_bad(1'b0) !== 0) $display("FAIL single_data: %0d bad words, word1=%h want 0", count_bad(1'b0), got[1]);
      else n_pass++;
      n_tot++;
      if (ncyc !== 132) $display("FAIL single_frame_len: got %0d want 132", ncyc); else n_pass++;
      n_tot++;
      if (fgrant !== 2'b01 || gbad !== 0) $display("FAIL single_grant: grant=%b changes=%0d want 01/0", fgrant, gbad);
      else n_pass++;
      cyc(1'b1);
      n_tot++;
      if ({grant, frame_busy, word_valid} !== 4'b0) $display("FAIL single_after_done: grant=%b busy=%b valid=%b want 0", grant, frame_busy, word_valid);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [1:0] eg;
      reset = 1'b1;
      repeat (2) cyc(1'b1);
      reset = 1'b0; src0_req = 1'b1; src1_req = 1'b1;
      for (int f = 0; f < 3; f++) begin
         eg = (f == 1) ? 2'b10 : 2'b01;
         run_frame(1'b0);
         n_tot++;
         if (fgrant !== eg || gbad !== 0) $display("FAIL rr_grant%0d: got %b want %b", f, fgrant, eg); else n_pass++;
         n_tot++;
         if (nw !== 67) $display("FAIL rr_count%0d: got %0d want 67", f, nw); else n_pass++;
         n_tot++;
         if (count_bad(f == 1) !== 0) $display("FAIL rr_data%0d: %0d bad, word2=%h want %h", f, count_bad(f == 1), got[2], exp_word(f == 1, 2));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      src1_req = 1'b0;
      run_frame(1'b1);
      n_tot++;
      if (nw !== 67) $display("FAIL stall_count: got %0d want 67", nw); else n_pass++;
      n_tot++;
      if (count_bad(1'b0) !== 0) $display("FAIL stall_data: %0d bad words want 0", count_bad(1'b0)); else n_pass++;
      n_tot++;
      if (unstable !== 0) $display("FAIL stall_stable: %0d unstable cycles want 0", unstable); else n_pass++;
      n_tot++;
      if (ncyc <= 132 || fgrant !== 2'b01) $display("FAIL stall_len_grant: len=%0d grant=%b want >132/01", ncyc, fgrant);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int c = 0;
      cyc(1'b1);
      while (!(rd_en && rd_idx == 6'd20) && c < 1800) begin cyc(1'b1); c++; end
      n_tot++;
      if (c >= 1800) $display("FAIL midreset_reach_idx20: timeout rd_idx=%0d want 20", rd_idx); else n_pass++;
      reset = 1'b1;
      cyc(1'b1);
      n_tot++;
      if ({grant, word_valid, frame_busy, frame_done, rd_en} !== 6'b0) begin
         $display("FAIL midreset_outputs: grant=%b valid=%b busy=%b done=%b rd_en=%b want 0",
                  grant, word_valid, frame_busy, frame_done, rd_en);
      end else n_pass++;
      reset = 1'b0;
      run_frame(1'b0);
      n_tot++;
      if (nw !== 67 || got[0] !== 32'd0 || count_bad(1'b0) !== 0) $display("FAIL midreset_restart: count=%0d first=%h want 67/0", nw, got[0]);
      else n_pass++;
      n_tot++;
      if (ncyc !== 132 || fgrant !== 2'b01) $display("FAIL midreset_restart_len: len=%0d grant=%b want 132/01", ncyc, fgrant);
      else n_pass++;
   endtask

   task automatic test_enable_gate();
      int busy_seen = 0;
      reset = 1'b1;
      cyc(1'b1);
      reset = 1'b0; enable = 1'b0; src0_req = 1'b1; src1_req = 1'b1;
      repeat (1100) begin cyc(1'b1); if (frame_busy) busy_seen++; end
      n_tot++;
      if (busy_seen !== 0) $display("FAIL enable_gate: busy cycles=%0d want 0", busy_seen); else n_pass++;
      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin cyc(1'b1); if (frame_busy) break; end
      n_tot++;
      if (frame_busy !== 1'b1) $display("FAIL enable_start: busy=%b want 1", frame_busy); else n_pass++;
      cyc(1'b1);
      n_tot++;
      if (grant !== 2'b01) $display("FAIL enable_first_grant: got %b want 01", grant); else n_pass++;
   endtask

   task automatic test_overrun();
      int c = 0, k = 0;
      reset = 1'b1;
      repeat (2) cyc(1'b1);
      enable = 1'b1; src0_req = 1'b1; src1_req = 1'b0; reset = 1'b0;
      while (!busy4 && c < 300) begin cyc(1'b1); c++; end
      n_tot++;
      if (c !== 101) $display("FAIL ovr_first_start: cycle %0d want 101", c); else n_pass++;
      while (!done4 && k < 300) begin cyc(1'b1); k++; end
      n_tot++;
      if (k !== 131) $display("FAIL ovr_frame_done: cycle %0d want 131", k); else n_pass++;
      cyc(1'b1); k++;
      n_tot++;
      if (busy4 !== 1'b0) $display("FAIL ovr_idle_gap: busy=%b want 0", busy4); else n_pass++;
      cyc(1'b1); k++;
      n_tot++;
      if (busy4 !== 1'b1) $display("FAIL ovr_back_to_back: busy=%b want 1", busy4); else n_pass++;
      while (k < 349) begin cyc(1'b1); k++; end
      n_tot++;
      if (ovr4 !== 1'b0) $display("FAIL ovr_not_yet: overrun=%b want 0", ovr4); else n_pass++;
      while (k < 509) begin cyc(1'b1); k++; end
      n_tot++;
      if (ovr4 !== 1'b1) $display("FAIL ovr_set: overrun=%b want 1", ovr4); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_stall();
      test_reset_mid_frame();
      test_enable_gate();
      test_overrun();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
